inst_fetch_ctrl: RTL and testbench

Instruction-fetch controller for the 5-stage MIPS core, directly downstream of the PC register. It turns the current PC into an SRAM-like instruction-bus transaction, tracks the outstanding request, and delivers fetched instructions into the IF/ID boundary. It raises `if_stall` to freeze the PC register's enable until the fetch completes. On a flush it cancels or drains any in-flight access so stale instructions never reach decode.

---
 rtl/cpu_defs.sv | 15 +
 rtl/inst_hold_buf.sv | 39 +++
 rtl/inst_fetch_ctrl.sv | 155 +++++++++++++++
 tb/tb_inst_fetch_ctrl.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/cpu_defs.sv
// Shared definitions for the MIPS core: reset vector, bubble encoding and
// the instruction-fetch FSM state type.
package cpu_defs;

   localparam logic [31:0] RESET_VECTOR = 32'hbfc0_0000;
   localparam logic [31:0] NOP_INST     = 32'h0000_0000;

   typedef enum logic [1:0] {
      StReq,
      StData,
      StHold,
      StDrop
   } fetch_state_e;

endpackage

// File: rtl/inst_hold_buf.sv
// One-entry {pc, inst} buffer that keeps a fetched instruction while decode
// is stalled. Clear has priority over load.
module inst_hold_buf (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic        clear,
   input  logic [31:0] load_pc,
   input  logic [31:0] load_inst,
   output logic        valid,
   output logic [31:0] buf_pc,
   output logic [31:0] buf_inst
);

   logic        valid_q;
   logic [31:0] pc_q;
   logic [31:0] inst_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         pc_q    <= 32'h0;
         inst_q  <= 32'h0;
      end else if (clear) begin
         valid_q <= 1'b0;
         pc_q    <= 32'h0;
         inst_q  <= 32'h0;
      end else if (load) begin
         valid_q <= 1'b1;
         pc_q    <= load_pc;
         inst_q  <= load_inst;
      end
   end

   assign valid    = valid_q;
   assign buf_pc   = pc_q;
   assign buf_inst = inst_q;

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Instruction-fetch controller: issues one SRAM-like bus read per PC, tracks
// the outstanding access and feeds the IF/ID registers, dropping stale data on flush.
module inst_fetch_ctrl #(
   parameter logic [31:0] NOP_INST = cpu_defs::NOP_INST
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc,
   input  logic        flush,
   input  logic        id_stall,
   output logic        inst_req,
   output logic [31:0] inst_addr,
   input  logic        inst_addr_ok,
   input  logic        inst_data_ok,
   input  logic [31:0] inst_rdata,
   output logic        if_stall,
   output logic        if_valid,
   output logic [31:0] if_pc,
   output logic [31:0] if_inst,
   output logic        if_adel
);

   import cpu_defs::*;

   fetch_state_e state_q, state_d;
   logic [31:0]  req_pc_q;
   logic         req_pc_load;

   logic         mis;
   logic         deliver;
   logic         buf_load, buf_clear, buf_valid;
   logic [31:0]  buf_pc, buf_inst;

   logic         ent_valid, ent_adel;
   logic [31:0]  ent_pc, ent_inst;

   logic         if_valid_q, if_adel_q;
   logic [31:0]  if_pc_q, if_inst_q;

   assign mis       = (pc[1:0] != 2'b00);
   assign inst_req  = (state_q == StReq) && !mis && !flush;
   assign inst_addr = pc;
   assign if_stall  = !deliver;

   always_comb begin
      state_d     = state_q;
      deliver     = 1'b0;
      buf_load    = 1'b0;
      buf_clear   = 1'b0;
      req_pc_load = 1'b0;
      ent_valid   = 1'b0;
      ent_pc      = pc;
      ent_inst    = NOP_INST;
      ent_adel    = 1'b0;
      unique case (state_q)
         StReq: begin
            if (mis) begin
               // Misaligned PC never reaches the bus; report AdEL as a bubble.
               deliver  = !id_stall;
               ent_adel = 1'b1;
            end else if (inst_req && inst_addr_ok) begin
               state_d     = StData;
               req_pc_load = 1'b1;
            end
         end
         StData: begin
            ent_valid = 1'b1;
            ent_pc    = req_pc_q;
            ent_inst  = inst_rdata;
            if (inst_data_ok) begin
               if (flush) begin
                  state_d = StReq;
               end else if (id_stall) begin
                  state_d  = StHold;
                  buf_load = 1'b1;
               end else begin
                  state_d = StReq;
                  deliver = 1'b1;
               end
            end else if (flush) begin
               state_d = StDrop;
            end
         end
         StHold: begin
            ent_valid = 1'b1;
            ent_pc    = buf_pc;
            ent_inst  = buf_inst;
            if (flush) begin
               state_d   = StReq;
               buf_clear = 1'b1;
            end else if (!id_stall) begin
               state_d   = StReq;
               deliver   = buf_valid;
               buf_clear = 1'b1;
            end
         end
         StDrop: begin
            if (inst_data_ok) state_d = StReq;
         end
         default: state_d = StReq;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StReq;
         req_pc_q <= 32'h0;
      end else begin
         state_q <= state_d;
         if (req_pc_load) req_pc_q <= pc;
      end
   end

   inst_hold_buf u_hold_buf (
      .clk       (clk),
      .rst       (rst),
      .load      (buf_load),
      .clear     (buf_clear),
      .load_pc   (req_pc_q),
      .load_inst (inst_rdata),
      .valid     (buf_valid),
      .buf_pc    (buf_pc),
      .buf_inst  (buf_inst)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         if_valid_q <= 1'b0;
         if_pc_q    <= 32'h0;
         if_inst_q  <= NOP_INST;
         if_adel_q  <= 1'b0;
      end else if (flush) begin
         if_valid_q <= 1'b0;
         if_inst_q  <= NOP_INST;
         if_adel_q  <= 1'b0;
      end else if (id_stall) begin
         if_valid_q <= if_valid_q;
      end else if (deliver) begin
         if_valid_q <= ent_valid;
         if_pc_q    <= ent_pc;
         if_inst_q  <= ent_inst;
         if_adel_q  <= ent_adel;
      end else begin
         if_valid_q <= 1'b0;
         if_inst_q  <= NOP_INST;
         if_adel_q  <= 1'b0;
      end
   end

   assign if_valid = if_valid_q;
   assign if_pc    = if_pc_q;
   assign if_inst  = if_inst_q;
   assign if_adel  = if_adel_q;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed, table-driven bench for inst_fetch_ctrl with hand-written
// sequences for reset during a dropped access.
module tb_inst_fetch_ctrl;

   logic        clk, rst;
   logic [31:0] pc;
   logic        flush, id_stall;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_addr_ok, inst_data_ok;
   logic [31:0] inst_rdata;
   logic        if_stall, if_valid, if_adel;
   logic [31:0] if_pc, if_inst;

   int total  = 0;
   int passed = 0;

   inst_fetch_ctrl #(.NOP_INST(32'h0000_0000)) dut (
      .clk          (clk),
      .rst          (rst),
      .pc           (pc),
      .flush        (flush),
      .id_stall     (id_stall),
      .inst_req     (inst_req),
      .inst_addr    (inst_addr),
      .inst_addr_ok (inst_addr_ok),
      .inst_data_ok (inst_data_ok),
      .inst_rdata   (inst_rdata),
      .if_stall     (if_stall),
      .if_valid     (if_valid),
      .if_pc        (if_pc),
      .if_inst      (if_inst),
      .if_adel      (if_adel)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic        flush, id_stall, addr_ok, data_ok;
      logic [31:0] rdata;
      logic        req, stall, valid;
      logic [31:0] opc, oinst;
      logic        adel;
   } vec_t;

   localparam int NVEC = 23;
   vec_t vecs [NVEC];

   function automatic vec_t mk(logic [31:0] p, logic fl, logic ids, logic aok, logic dok,
                               logic [31:0] rd, logic rq, logic st, logic v,
                               logic [31:0] opc, logic [31:0] oi, logic ad);
      vec_t r;
      r.pc = p; r.flush = fl; r.id_stall = ids; r.addr_ok = aok; r.data_ok = dok;
      r.rdata = rd; r.req = rq; r.stall = st; r.valid = v; r.opc = opc; r.oinst = oi;
      r.adel = ad;
      return r;
   endfunction

   task automatic chk(input string name, input int idx, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
   endtask

   task automatic chk_regs(input int idx, input logic v, input logic [31:0] p,
                           input logic [31:0] i, input logic a);
      chk("if_valid", idx, {31'h0, if_valid}, {31'h0, v});
      chk("if_pc", idx, if_pc, p);
      chk("if_inst", idx, if_inst, i);
      chk("if_adel", idx, {31'h0, if_adel}, {31'h0, a});
   endtask

   task automatic drive(input logic [31:0] p, input logic fl, input logic ids, input logic aok,
                        input logic dok, input logic [31:0] rd);
      pc = p; flush = fl; id_stall = ids; inst_addr_ok = aok; inst_data_ok = dok;
      inst_rdata = rd;
   endtask

   initial begin
      //            pc            fl ids aok dok rdata          req st v  if_pc         if_inst       adel
      vecs[0]  = mk(32'hbfc00000, 0, 0, 0, 0, 32'h0,        1, 1, 0, 32'h0,        32'h0,        0);
      vecs[1]  = mk(32'hbfc00000, 0, 0, 1, 0, 32'h0,        1, 1, 0, 32'h0,        32'h0,        0);
      vecs[2]  = mk(32'hbfc00000, 0, 0, 0, 1, 32'h3c080001, 0, 0, 0, 32'h0,        32'h0,        0);
      vecs[3]  = mk(32'hbfc00004, 0, 0, 0, 0, 32'h0,        1, 1, 1, 32'hbfc00000, 32'h3c080001, 0);
      vecs[4]  = mk(32'hbfc00004, 0, 0, 1, 0, 32'h0,        1, 1, 0, 32'hbfc00000, 32'h0,        0);
      vecs[5]  = mk(32'hbfc00004, 0, 1, 0, 1, 32'h24090002, 0, 1, 0, 32'hbfc00000, 32'h0,        0);
      vecs[6]  = mk(32'hbfc00004, 0, 1, 0, 0, 32'h0,        0, 1, 0, 32'hbfc00000, 32'h0,        0);
      vecs[7]  = mk(32'hbfc00004, 0, 0, 0, 0, 32'h0,        0, 0, 0, 32'hbfc00000, 32'h0,        0);
      vecs[8]  = mk(32'hbfc00008, 0, 0, 0, 0, 32'h0,        1, 1, 1, 32'hbfc00004, 32'h24090002, 0);
      vecs[9]  = mk(32'hbfc00008, 0, 0, 1, 0, 32'h0,        1, 1, 0, 32'hbfc00004, 32'h0,        0);
      vecs[10] = mk(32'hbfc00008, 1, 0, 0, 0, 32'h0,        0, 1, 0, 32'hbfc00004, 32'h0,        0);
      vecs[11] = mk(32'hbfc00380, 0, 0, 0, 0, 32'h0,        0, 1, 0, 32'hbfc00004, 32'h0,        0);
      vecs[12] = mk(32'hbfc00380, 0, 0, 0, 0, 32'h0,        0, 1, 0, 32'hbfc00004, 32'h0,        0);
      vecs[13] = mk(32'hbfc00380, 0, 0, 0, 1, 32'hdeadbeef, 0, 1, 0, 32'hbfc00004, 32'h0,        0);
      vecs[14] = mk(32'hbfc00380, 0, 0, 0, 0, 32'h0,        1, 1, 0, 32'hbfc00004, 32'h0,        0);
      vecs[15] = mk(32'hbfc00380, 0, 0, 1, 0, 32'h0,        1, 1, 0, 32'hbfc00004, 32'h0,        0);
      vecs[16] = mk(32'hbfc00380, 1, 0, 0, 1, 32'h11111111, 0, 1, 0, 32'hbfc00004, 32'h0,        0);
      vecs[17] = mk(32'hbfc00380, 0, 0, 1, 0, 32'h0,        1, 1, 0, 32'hbfc00004, 32'h0,        0);
      vecs[18] = mk(32'hbfc00380, 0, 0, 0, 1, 32'h8c020000, 0, 0, 0, 32'hbfc00004, 32'h0,        0);
      vecs[19] = mk(32'hbfc00002, 0, 0, 0, 0, 32'h0,        0, 0, 1, 32'hbfc00380, 32'h8c020000, 0);
      vecs[20] = mk(32'hbfc00002, 0, 1, 0, 0, 32'h0,        0, 1, 0, 32'hbfc00002, 32'h0,        1);
      vecs[21] = mk(32'hbfc00002, 1, 0, 0, 0, 32'h0,        0, 0, 0, 32'hbfc00002, 32'h0,        1);
      vecs[22] = mk(32'hbfc00380, 0, 0, 1, 0, 32'h0,        1, 1, 0, 32'hbfc00002, 32'h0,        0);

      rst = 1'b1;
      drive(cpu_defs::RESET_VECTOR, 0, 0, 0, 0, 32'h0);
      @(negedge clk);
      #1 chk_regs(-1, 1'b0, 32'h0, 32'h0, 1'b0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < NVEC; i++) begin
         drive(vecs[i].pc, vecs[i].flush, vecs[i].id_stall, vecs[i].addr_ok,
               vecs[i].data_ok, vecs[i].rdata);
         #1;
         chk("inst_req", i, {31'h0, inst_req}, {31'h0, vecs[i].req});
         chk("inst_addr", i, inst_addr, vecs[i].pc);
         chk("if_stall", i, {31'h0, if_stall}, {31'h0, vecs[i].stall});
         chk_regs(i, vecs[i].valid, vecs[i].opc, vecs[i].oinst, vecs[i].adel);
         @(negedge clk);
      end

      // FSM is in DATA here; flush sends it to DROP, then reset it there.
      drive(32'hbfc00380, 1, 0, 0, 0, 32'h0);
      #1 chk("drop_req", 100, {31'h0, inst_req}, 32'h0);
      @(negedge clk);
      drive(32'hbfc00500, 0, 0, 0, 0, 32'h0);
      #1;
      chk("drop_req", 101, {31'h0, inst_req}, 32'h0);
      chk("drop_stall", 101, {31'h0, if_stall}, 32'h1);
      chk_regs(101, 1'b0, 32'hbfc00002, 32'h0, 1'b0);
      #2;
      rst = 1'b1;
      pc  = cpu_defs::RESET_VECTOR;
      #1;
      chk_regs(102, 1'b0, 32'h0, 32'h0, 1'b0);
      chk("rst_req", 102, {31'h0, inst_req}, 32'h1);
      @(negedge clk);
      rst = 1'b0;
      drive(cpu_defs::RESET_VECTOR, 0, 0, 1, 0, 32'h0);
      #1;
      chk("restart_req", 103, {31'h0, inst_req}, 32'h1);
      chk("restart_addr", 103, inst_addr, 32'hbfc00000);
      @(negedge clk);
      drive(cpu_defs::RESET_VECTOR, 0, 0, 0, 1, 32'h3c1d0010);
      #1;
      chk("restart_stall", 104, {31'h0, if_stall}, 32'h0);
      chk("restart_req", 104, {31'h0, inst_req}, 32'h0);
      @(negedge clk);
      drive(32'hbfc00004, 0, 0, 0, 0, 32'h0);
      #1;
      chk_regs(105, 1'b1, 32'hbfc00000, 32'h3c1d0010, 1'b0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
